// File: rtl/shift_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : shift_sequencer                                               |
// | Description: Round-robin arbiter in front of a shared shift datapath.      |
// |              Each accepted request is shifted at most 2 bits per cycle     |
// |              and the result is returned over a valid/ready handshake,      |
// |              tagged with the ID of the requester that owns it.             |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module shift_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [1:WIDTH] req0_data,
  input  logic [2:0]     req0_amt,
  input  logic           req0_dir,
  input  logic           req0_arith,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [1:WIDTH] req1_data,
  input  logic [2:0]     req1_amt,
  input  logic           req1_dir,
  input  logic           req1_arith,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [1:WIDTH] res_data,
  output logic           res_id,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [1:WIDTH] work_q, work_d;          // operand being shifted
  logic [2:0]     rem_q, rem_d;            // bits still to shift
  logic           dir_q, dir_d;            // 0 = left, 1 = right
  logic           fill_q, fill_d;          // bit shifted in on right shifts
  logic [1:WIDTH] res_data_q, res_data_d;
  logic           res_valid_q, res_valid_d;
  logic           res_id_q, res_id_d;
  logic           last_grant_q, last_grant_d;
  logic           busy_q, busy_d;

  logic           w_idle;
  logic           w_grant;
  logic           w_accept;
  logic [1:WIDTH] w_sel_data;
  logic [2:0]     w_sel_amt;
  logic           w_sel_dir;
  logic           w_sel_arith;
  logic [1:WIDTH] w_step1;
  logic [1:WIDTH] w_step2;
  logic [1:WIDTH] w_step;
  logic [2:0]     w_rem_next;

  // Single-bit shift; bit 1 is the MSB, so "left" moves data toward bit 1.
  // The sign fill is captured at accept time, so it always reflects the
  // original operand MSB regardless of how many steps have run.
  function automatic logic [1:WIDTH] shift_one(input logic [1:WIDTH] v,
                                               input logic           dir,
                                               input logic           fill);
    logic [1:WIDTH] r;
    if (!dir) begin
      r = {v[2:WIDTH], 1'b0};
    end else begin
      r = {fill, v[1:WIDTH-1]};
    end
    return r;
  endfunction

  // Arbitration: a lone requester wins; on contention the one not served last
  // time wins. Readies depend only on state and the valids.
  always_comb begin
    w_idle      = (state_q == IDLE);
    w_grant     = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    req0_ready  = w_idle && req0_valid && !w_grant;
    req1_ready  = w_idle && req1_valid &&  w_grant;
    w_accept    = req0_ready || req1_ready;
    w_sel_data  = w_grant ? req1_data  : req0_data;
    w_sel_amt   = w_grant ? req1_amt   : req0_amt;
    w_sel_dir   = w_grant ? req1_dir   : req0_dir;
    w_sel_arith = w_grant ? req1_arith : req0_arith;
  end

  // One datapath step: shift by 2 while at least 2 bits remain, else by 1.
  always_comb begin
    w_step1 = shift_one(work_q, dir_q, fill_q);
    w_step2 = shift_one(w_step1, dir_q, fill_q);
    if (rem_q >= 3'd2) begin
      w_step     = w_step2;
      w_rem_next = rem_q - 3'd2;
    end else begin
      w_step     = w_step1;
      w_rem_next = 3'd0;
    end
  end

  // Next-state and next-output logic for the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    state_d      = state_q;
    work_d       = work_q;
    rem_d        = rem_q;
    dir_d        = dir_q;
    fill_d       = fill_q;
    res_data_d   = res_data_q;
    res_valid_d  = res_valid_q;
    res_id_d     = res_id_q;
    last_grant_d = last_grant_q;

    case (state_q)
      IDLE: begin
        if (w_accept) begin
          work_d       = w_sel_data;
          rem_d        = w_sel_amt;
          dir_d        = w_sel_dir;
          fill_d       = w_sel_dir && w_sel_arith && w_sel_data[1];
          res_id_d     = w_grant;
          last_grant_d = w_grant;
          if (w_sel_amt == 3'd0) begin
            state_d     = DONE;
            res_data_d  = w_sel_data;
            res_valid_d = 1'b1;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d = w_step;
        rem_d  = w_rem_next;
        if (w_rem_next == 3'd0) begin
          state_d     = DONE;
          res_data_d  = w_step;
          res_valid_d = 1'b1;
        end
      end
      DONE: begin
        // Result is held until consumed; no accept is possible this cycle
        // because the readies only assert in IDLE.
        if (res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        res_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      work_q       <= '0;
      rem_q        <= 3'd0;
      dir_q        <= 1'b0;
      fill_q       <= 1'b0;
      res_data_q   <= '0;
      res_valid_q  <= 1'b0;
      res_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      work_q       <= work_d;
      rem_q        <= rem_d;
      dir_q        <= dir_d;
      fill_q       <= fill_d;
      res_data_q   <= res_data_d;
      res_valid_q  <= res_valid_d;
      res_id_q     <= res_id_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_shift_sequencer                                            |
// | Description: Directed bench for shift_sequencer with a result scoreboard.  |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_shift_sequencer;
  localparam int WIDTH = 4;

  logic           clk;
  logic           rst_n;
  logic           req0_valid, req0_ready, req0_dir, req0_arith;
  logic [1:WIDTH] req0_data;
  logic [2:0]     req0_amt;
  logic           req1_valid, req1_ready, req1_dir, req1_arith;
  logic [1:WIDTH] req1_data;
  logic [2:0]     req1_amt;
  logic           res_valid, res_ready, res_id, busy;
  logic [1:WIDTH] res_data;

  shift_sequencer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .req0_dir   (req0_dir),
    .req0_arith (req0_arith),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .req1_dir   (req1_dir),
    .req1_arith (req1_arith),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_id     (res_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic           id;
    logic [1:WIDTH] data;
  } exp_t;

  exp_t exp_q[$];
  int   grant_log[$];
  int   acc_cyc;
  int   exp_lat;
  bit   lat_pending;
  bit   acc0_flag, acc1_flag;
  bit   prev_hold;
  logic [1:WIDTH] prev_data;
  logic prev_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference shift using native signed/unsigned shift operators on a
  // conventionally ordered vector (leftmost bit = MSB = bus bit 1).
  function automatic logic [1:WIDTH] model(input logic [1:WIDTH] d, input logic [2:0] amt,
                                           input logic dir, input logic arith);
    logic signed [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    x = d;
    if (!dir)       y = x << amt;
    else if (arith) y = x >>> amt;
    else            y = $unsigned(x) >> amt;
    return y;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      lat_pending = 0;
      prev_hold   = 0;
    end else begin
      chk("one_ready", {31'd0, req0_ready & req1_ready}, 0);
      if (req0_valid && req0_ready) begin
        exp_q.push_back('{1'b0, model(req0_data, req0_amt, req0_dir, req0_arith)});
        grant_log.push_back(0);
        acc0_flag   = 1;
        acc_cyc     = cyc + 1;
        exp_lat     = (int'(req0_amt) + 1) / 2;
        lat_pending = 1;
      end
      if (req1_valid && req1_ready) begin
        exp_q.push_back('{1'b1, model(req1_data, req1_amt, req1_dir, req1_arith)});
        grant_log.push_back(1);
        acc1_flag   = 1;
        acc_cyc     = cyc + 1;
        exp_lat     = (int'(req1_amt) + 1) / 2;
        lat_pending = 1;
      end
      if (res_valid) begin
        if (lat_pending) begin
          chk("latency", cyc - acc_cyc, exp_lat);
          lat_pending = 0;
        end
        if (prev_hold) begin
          chk("hold_data", res_data, prev_data);
          chk("hold_id", res_id, prev_id);
        end
        if (res_ready) begin
          chk("sb_nonempty", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_data", res_data, e.data);
            chk("sb_id", res_id, e.id);
          end
        end
      end
      prev_hold = res_valid && !res_ready;
      prev_data = res_data;
      prev_id   = res_id;
    end
  end

  task automatic do_req(input logic id, input logic [1:WIDTH] d, input logic [2:0] a,
                        input logic dr, input logic ar, input logic [1:WIDTH] exp,
                        input string tag);
    logic got;
    @(posedge clk); #1;
    if (!id) begin
      req0_valid = 1; req0_data = d; req0_amt = a; req0_dir = dr; req0_arith = ar;
    end else begin
      req1_valid = 1; req1_data = d; req1_amt = a; req1_dir = dr; req1_arith = ar;
    end
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = id ? req1_ready : req0_ready;
    end
    chk({tag, "_accept"}, got, 1);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    req0_data  = $urandom; req1_data = $urandom;
    chk({tag, "_busy"}, busy, 1);
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = res_valid;
    end
    chk({tag, "_valid"}, got, 1);
    chk({tag, "_data"}, res_data, exp);
    chk({tag, "_id"}, res_id, id);
    @(posedge clk); #1;
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic drain();
    for (int n = 0; n < 30 && busy; n++) @(posedge clk);
    #1;
    chk("drain_idle", busy, 0);
  endtask

  initial begin
    rst_n = 0; res_ready = 1;
    req0_valid = 0; req0_data = '0; req0_amt = '0; req0_dir = 0; req0_arith = 0;
    req1_valid = 0; req1_data = '0; req1_amt = '0; req1_dir = 0; req1_arith = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", res_data, 0);
    chk("rst_id", res_id, 0);
    chk("rst_ready0", req0_ready, 0);
    @(posedge clk); #1;
    rst_n = 1;

    // Contention: both requesters held valid, new data after each accept.
    grant_log.delete();
    acc0_flag = 0; acc1_flag = 0;
    req0_data = 4'b0011; req0_amt = 3'd1; req0_dir = 0; req0_arith = 0;
    req1_data = 4'b1100; req1_amt = 3'd2; req1_dir = 1; req1_arith = 1;
    req0_valid = 1; req1_valid = 1;
    for (int n = 0; n < 80 && grant_log.size() < 4; n++) begin
      @(posedge clk); #1;
      if (acc0_flag) begin req0_data = $urandom; acc0_flag = 0; end
      if (acc1_flag) begin req1_data = $urandom; acc1_flag = 0; end
    end
    req0_valid = 0; req1_valid = 0;
    chk("fair_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      chk($sformatf("fair_grant%0d", i), grant_log[i], i % 2);
    drain();

    do_req(1'b0, 4'b1011, 3'd2, 1'b0, 1'b0, 4'b1100, "left2");
    do_req(1'b1, 4'b1011, 3'd3, 1'b1, 1'b1, 4'b1111, "asr3");
    do_req(1'b1, 4'b1011, 3'd3, 1'b1, 1'b0, 4'b0001, "lsr3");
    do_req(1'b0, 4'b0110, 3'd0, 1'b0, 1'b0, 4'b0110, "amt0");
    do_req(1'b1, 4'b1111, 3'd7, 1'b0, 1'b1, 4'b0000, "left7");
    do_req(1'b0, 4'b1000, 3'd5, 1'b1, 1'b1, 4'b1111, "asr5");
    do_req(1'b0, 4'b0111, 3'd1, 1'b1, 1'b1, 4'b0011, "asr1_pos");

    for (int i = 0; i < 6; i++) begin
      logic [1:WIDTH] d;
      logic [2:0] a;
      logic dr, ar, id;
      d = $urandom; a = $urandom; dr = $urandom; ar = $urandom; id = $urandom;
      do_req(id, d, a, dr, ar, model(d, a, dr, ar), $sformatf("rnd%0d", i));
    end

    // Backpressure: result held while res_ready is low; a competing valid
    // is present but withdrawn before ever being served.
    @(posedge clk); #1;
    res_ready = 0;
    req1_valid = 1; req1_data = 4'b0110; req1_amt = 3'd1; req1_dir = 0; req1_arith = 0;
    @(posedge clk); #1;
    req1_valid = 0;
    req0_valid = 1; req0_data = 4'b1010; req0_amt = 3'd0;
    for (int n = 0; n < 20 && !res_valid; n++) @(negedge clk);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("bp_valid", res_valid, 1);
      chk("bp_data", res_data, 4'b1100);
      chk("bp_id", res_id, 1);
      chk("bp_busy", busy, 1);
      chk("bp_rdy", {30'd0, req0_ready, req1_ready}, 0);
    end
    @(posedge clk); #1;
    res_ready = 1; req0_valid = 0;
    @(posedge clk); #1;
    chk("bp_release_busy", busy, 0);
    chk("bp_release_valid", res_valid, 0);

    // Reset in the middle of an amt=7 shift owned by req0.
    @(posedge clk); #1;
    req0_valid = 1; req0_data = 4'b1111; req0_amt = 3'd7; req0_dir = 0;
    for (int n = 0; n < 20 && !req0_ready; n++) @(negedge clk);
    @(posedge clk); #1;
    req0_valid = 0;
    @(posedge clk); #1;
    chk("mid_busy", busy, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_data", res_data, 0);
    chk("mid_rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1;
    req0_valid = 1; req0_data = 4'b0101; req0_amt = 3'd1; req0_dir = 1; req0_arith = 0;
    req1_valid = 1; req1_data = 4'b1001; req1_amt = 3'd1; req1_dir = 1; req1_arith = 1;
    @(negedge clk);
    chk("post_rst_grant0", req0_ready, 1);
    chk("post_rst_grant1", req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    drain();
    @(negedge clk);
    chk("sb_empty_end", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/shift_sequencer.md
# shift_sequencer

Shares one shift datapath between two requesters. Each request carries a WIDTH-bit operand, a shift amount of 0–7, a direction and a fill mode. The block serves requests in round-robin order. It performs each shift as a sequence of steps of at most 2 bits per cycle, the same per-cycle capability as the existing fixed shift-by-2 unit, and returns the result over a valid/ready handshake tagged with the requester ID. It sits between client blocks and the shifter and is the only master of the shifter.

## Interface
- WIDTH, 4, operand/result width in bits (MSB = bit 1, buses declared [1:WIDTH]).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid / req1_valid  input  1  request present.
- req0_ready / req1_ready  output  1  request accepted this cycle when high with valid.
- req0_data / req1_data  input  WIDTH  operand.
- req0_amt / req1_amt  input  3  shift amount, 0–7.
- req0_dir / req1_dir  input  1  0 = shift left, 1 = shift right.
- req0_arith / req1_arith  input  1  right shifts only: 1 = sign-fill, 0 = zero-fill. Ignored for left shifts.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- res_data  output  WIDTH  shifted result.
- res_id  output  1  ID of the requester that owns res_data.
- busy  output  1  high whenever state is not IDLE.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE. Reset state is IDLE.
- **Arbitration (IDLE only):**
  - If exactly one req*_valid is high, that requester is granted.
  - If both are high, the requester not granted last time is granted.
  - last_grant resets to 1, so req0 wins the first contention.
- **Ready signals:**
  - reqN_ready = (state == IDLE) && granted == N. This is combinational from state and the valids.
  - At most one ready is high in any cycle. Both are low outside IDLE.
- **Accept** occurs when valid && ready at a rising edge. On accept the block:
  - latches data, amt, dir and arith into working registers;
  - sets res_id and last_grant to N;
  - goes to SHIFT if amt ≠ 0, otherwise to DONE.
- **SHIFT step, once per cycle:**
  - If remaining ≥ 2: shift by 2 and subtract 2 from remaining.
  - Otherwise: shift by 1 and set remaining to 0.
  - Go to DONE when the new remaining is 0.
- **Fill rules:**
  - Left shifts fill with 0.
  - Right shifts with arith = 1 replicate the original bit 1 (MSB).
  - Right shifts with arith = 0 fill with 0.
  - If amt ≥ WIDTH, the result is all-fill, reached naturally by iteration. No special case.
- **DONE:**
  - res_valid = 1. res_data and res_id are held stable until res_ready.
  - On res_valid && res_ready, go to IDLE.
  - No new request is accepted in that same cycle.
- **Requester protocol:** a requester holds valid and its fields stable until ready. Fields are sampled only at accept, so changes made before accept are harmless.
- **Withdrawal:** a valid dropped before accept is not an error. The request is simply not served.
- **Reset:**
  - Reset mid-operation aborts the in-flight request with no output.
  - All registers clear: state = IDLE, res_valid = 0, res_data = 0, res_id = 0, last_grant = 1, busy = 0.
  - Ready outputs follow their combinational rule (IDLE), so they may be high during reset if a valid is high. Requesters do not sample ready while rst_n is low.

## Timing
- Let accept occur at edge T and k = ceil(amt/2).
  - res_valid rises in the cycle after edge T+k. For amt = 0, k = 0, so it rises right after edge T.
  - busy rises in the cycle after edge T.
  - Minimum accept-to-result latency is 1 cycle (amt = 0). Maximum is 5 cycles (amt = 7: steps 2, 2, 2, 1).
- Let the result be consumed at edge R.
  - State is IDLE after edge R.
  - The earliest next accept is at edge R+1.
  - Throughput is one request per k + 2 cycles with no backpressure.
- res_valid, res_data, res_id and busy are registered outputs with no combinational input-to-output paths. req*_ready is the only combinational output.

## Test plan
- **Single left shift:** req0 data=1011, amt=2, dir=0, res_ready=1 → req0_ready at T, res_valid one cycle after T+1, res_data=1100, res_id=0.
- **Arithmetic right, odd amount:** req1 data=1011, amt=3, dir=1, arith=1 → two SHIFT cycles (2 then 1), res_data=1111, res_id=1. Repeat with arith=0 → res_data=0001.
- **Contention fairness:** both valid continuously with distinct data → grants alternate 0, 1, 0, 1 starting with req0; never both ready in one cycle; each requester waits at most one service.
- **Zero and oversize amounts:** amt=0, data=0110 → res_data=0110 one cycle after accept. amt=7 left, data=1111 → res_data=0000 after 4 SHIFT cycles.
- **Backpressure:** res_ready low for 5 cycles in DONE → res_valid, res_data and res_id held constant, both readies low, busy=1. res_ready high → IDLE next cycle.
- **Reset mid-shift:** assert rst_n=0 during SHIFT of amt=7 → res_valid=0, res_data=0, busy=0 at once. After release, first contention grants req0.
